// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// default geometry/latency and the latency counter width.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_DEPTH_WORDS = 256;
  localparam int DEF_LATENCY     = 2;
  localparam int CNT_W           = 4;

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage request/response bundle between the pipeline (master) and the
// data-memory responder (slave).
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both 1; req_write/req_addr/req_wdata are sampled only on that
// edge. rsp_valid is a one-cycle strobe with no back-pressure; rsp_rdata and
// rsp_error are meaningful only while rsp_valid=1 and read 0 otherwise.
// stall tells the pipeline to hold its registers. dbg_state mirrors the
// responder FSM state for observation.
interface dmem_responder_if;
  import dmem_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        stall;
  state_t      dbg_state;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_error, stall, dbg_state
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error, stall, dbg_state
  );

endinterface

// File: rtl/dmem_sram_array.sv
// Word storage for the responder: synchronous write, combinational read,
// no reset so contents survive a responder reset.
module dmem_sram_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  // Commit a word when the responder asserts its write enable.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_idx] <= i_wdata;
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for a pipeline MEM stage.
// One access in flight: IDLE accepts, WAIT counts down LATENCY-1..0,
// RESP strobes the response for one cycle and returns to IDLE.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (misaligned accesses
// complete with rsp_error=1, no write and rsp_rdata=0).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int LATENCY     = DEF_LATENCY
) (
  input logic              clk,
  input logic              reset,
  dmem_responder_if.slave  bus
);

  localparam int                 IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_write;
  logic [IDX_W-1:0]   r_idx;
  logic [31:0]        r_wdata;
  logic [31:0]        r_rdata;
  logic               w_accept;
  logic               w_commit;
  logic               w_fault;
  logic               w_mem_we;
  logic [31:0]        w_mem_rdata;
  logic               w_unused_addr;

  assign w_accept = (r_state == IDLE) && bus.req_valid;
  // The WAIT->RESP edge is where stores land and loads sample memory.
  assign w_commit = (r_state == WAIT) && (r_cnt == '0);
  assign w_mem_we = w_commit && r_write && !w_fault;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.req_valid) w_next = WAIT;
      WAIT:    if (r_cnt == '0)   w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Latch the request on acceptance, run the countdown, capture load data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_cnt   <= CNT_LOAD;
        r_write <= bus.req_write;
        r_idx   <= bus.req_addr[IDX_W+1:2];
        r_wdata <= bus.req_wdata;
      end else if ((r_state == WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_commit) r_rdata <= (r_write || w_fault) ? 32'd0 : w_mem_rdata;
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic r_misalign;
  logic r_error;

  // Remember whether the accepted access was misaligned and report it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_misalign <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      if (w_accept) r_misalign <= (bus.req_addr[1:0] != 2'b00);
      if (w_commit) r_error    <= r_misalign;
    end
  end

  assign w_fault       = r_misalign;
  assign bus.rsp_error = (r_state == RESP) && r_error;
  assign w_unused_addr = ^{1'b0, bus.req_addr[31:IDX_W+2]};
`else
  assign w_fault       = 1'b0;
  assign bus.rsp_error = 1'b0;
  assign w_unused_addr = ^{bus.req_addr[31:IDX_W+2], bus.req_addr[1:0]};
`endif

  dmem_sram_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_idx   (r_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_mem_rdata)
  );

  assign bus.req_ready = (r_state == IDLE);
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_rdata = (r_state == RESP) ? r_rdata : 32'd0;
  // Hold the pipeline while an access is pending; release it in RESP.
  assign bus.stall     = (r_state == WAIT) || ((r_state == IDLE) && bus.req_valid);
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed accesses with literal expectations,
// plus a cycle-level behavioural model compared against the DUT each cycle.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int L  = 2;
  localparam int DW = 256;
  localparam int IW = $clog2(DW);

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_responder_if bus();

  dmem_responder #(.DEPTH_WORDS(DW), .LATENCY(L)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rsp_seen = 0;

  logic [31:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // One access at a time; a request seen in cycle c while free is taken on
  // the following edge and answered in cycle c+1+L. Memory is updated when
  // the response appears, so an access aborted by reset never lands.
  logic [31:0] m_mem   [DW];
  bit          m_known [DW];
  bit          m_pend  = 1'b0;
  int          m_resp_c;
  logic        m_w;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        e_valid;
  logic        e_err;
  logic [31:0] e_rd;
  int          e_idx;

  function automatic logic m_fault(input logic [31:0] a);
`ifdef DMEM_MISALIGN_TRAP_EN
    return (a % 4) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (bus.rsp_valid) rsp_seen++;
    if (reset) begin
      m_pend = 1'b0;
      check32("reset req_ready", bus.req_ready, 1'b1);
      check32("reset rsp_valid", bus.rsp_valid, 1'b0);
      check32("reset rsp_rdata", bus.rsp_rdata, 32'd0);
    end else begin
      e_valid = m_pend && (cyc == m_resp_c);
      check32("model req_ready", bus.req_ready, !m_pend);
      check32("model stall", bus.stall, m_pend ? (cyc < m_resp_c) : bus.req_valid);
      check32("model rsp_valid", bus.rsp_valid, e_valid);
      if (e_valid) begin
        e_idx = int'((m_addr / 4) % DW);
        e_err = m_fault(m_addr);
        check32("model rsp_error", bus.rsp_error, e_err);
        if (m_w) begin
          check32("model store rdata", bus.rsp_rdata, 32'd0);
          if (!e_err) begin
            m_mem[e_idx]   = m_wdata;
            m_known[e_idx] = 1'b1;
          end
        end else begin
          e_rd = e_err ? 32'd0 : m_mem[e_idx];
          if (e_err || m_known[e_idx]) check32("model load rdata", bus.rsp_rdata, e_rd);
        end
        m_pend = 1'b0;
      end else begin
        check32("model idle rdata", bus.rsp_rdata, 32'd0);
        check32("model idle error", bus.rsp_error, 1'b0);
        if (!m_pend && bus.req_valid) begin
          m_pend   = 1'b1;
          m_resp_c = cyc + 1 + L;
          m_w      = bus.req_write;
          m_addr   = bus.req_addr;
          m_wdata  = bus.req_wdata;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+#1; presents a request, waits for acceptance, then
  // scrambles the request inputs while the access is in flight.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    int n;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (bus.req_ready) break;
      n++;
    end
    if (n >= 20) begin
      checks++; failures++;
      $display("FAIL accept timeout: got no req_ready expected ready within 20 cycles");
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom_range(0, 1));
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
  endtask

  task automatic txn(input string name, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_rd, input logic exp_err,
                     output int lat, output int stall_n, output int nready_n);
    exp_q.push_back(exp_rd);
    issue(w, a, d);
    lat = -1; stall_n = 0; nready_n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.stall) stall_n++;
      if (!bus.req_ready) nready_n++;
      if (bus.rsp_valid) begin
        lat = k;
        check32({name, " rdata"}, bus.rsp_rdata, exp_q.pop_front());
        check32({name, " error"}, bus.rsp_error, exp_err);
        break;
      end
    end
    check32({name, " latency"}, lat, L);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  int lat, stall_n, nready_n, t1, t2, seen0, n;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    repeat (3) @(posedge clk);
    #1;
    check32("rst dbg_state", bus.dbg_state, IDLE);
    check32("rst rsp_error", bus.rsp_error, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;
    check32("post-rst req_ready", bus.req_ready, 1'b1);

    // Store then load at 0x10.
    txn("st 0x10", 1'b1, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0, lat, stall_n, nready_n);
    check32("st 0x10 stall cycles", stall_n, 2);
    txn("ld 0x10", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, lat, stall_n, nready_n);
    check32("ld 0x10 ready-low cycles", nready_n, L + 1);

    // Wrap-around: 0x400 aliases word 0 with 256 words.
    txn("st 0x400", 1'b1, 32'h400, 32'h12345678, 32'd0, 1'b0, lat, stall_n, nready_n);
    txn("ld 0x000", 1'b0, 32'h0, 32'h0, 32'h12345678, 1'b0, lat, stall_n, nready_n);

    // Back-to-back with req_valid held: address changes mid-WAIT must not
    // disturb the first load; the second load is taken after RESP.
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h10;
    n = 0;
    while (n < 20) begin @(negedge clk); if (bus.req_ready) break; n++; end
    @(posedge clk); #1;
    bus.req_addr = 32'h0; bus.req_wdata = 32'hFFFF0000;
    t1 = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin t1 = cyc; check32("b2b first rdata", bus.rsp_rdata, 32'hDEADBEEF); break; end
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    t2 = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin t2 = cyc; check32("b2b second rdata", bus.rsp_rdata, 32'h12345678); break; end
    end
    check32("b2b spacing", t2 - t1, L + 2);
    @(posedge clk); #1;

    // Reset in the middle of WAIT discards a store.
    txn("st 0x20", 1'b1, 32'h20, 32'h11112222, 32'd0, 1'b0, lat, stall_n, nready_n);
    seen0 = rsp_seen;
    issue(1'b1, 32'h20, 32'hCAFEF00D);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check32("aborted store no rsp", rsp_seen - seen0, 0);
    txn("ld 0x20 after abort", 1'b0, 32'h20, 32'h0, 32'h11112222, 1'b0, lat, stall_n, nready_n);

    // Misaligned store to 0x22.
`ifdef DMEM_MISALIGN_TRAP_EN
    txn("st 0x22 trap", 1'b1, 32'h22, 32'hA5A5A5A5, 32'd0, 1'b1, lat, stall_n, nready_n);
    txn("ld 0x20 unchanged", 1'b0, 32'h20, 32'h0, 32'h11112222, 1'b0, lat, stall_n, nready_n);
    txn("ld 0x21 trap", 1'b0, 32'h21, 32'h0, 32'd0, 1'b1, lat, stall_n, nready_n);
`else
    txn("st 0x22", 1'b1, 32'h22, 32'hA5A5A5A5, 32'd0, 1'b0, lat, stall_n, nready_n);
    txn("ld 0x20 written", 1'b0, 32'h20, 32'h0, 32'hA5A5A5A5, 1'b0, lat, stall_n, nready_n);
`endif

    // Top word of the array.
    txn("st 0x3FC", 1'b1, 32'h3FC, 32'h0BADF00D, 32'd0, 1'b0, lat, stall_n, nready_n);
    txn("ld 0x7FC", 1'b0, 32'h7FC, 32'h0, 32'h0BADF00D, 1'b0, lat, stall_n, nready_n);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: `clk` and `reset`.
REQ-002 Parameter DEPTH_WORDS, default 256: number of 32-bit words; SHALL be a power of two, at least 4.
REQ-003 Parameter LATENCY, default 2: cycles from request acceptance to response; SHALL be 1..15.
REQ-004 Ports:
- clk  in  1  rising-edge clock
- reset  in  1  async active-high reset
- req_valid  in  1  MEM-stage access request
- req_ready  out  1  responder can accept
- req_write  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  32  load data; 0 for stores
- rsp_error  out  1  access fault, qualified by rsp_valid
- stall  out  1  hold the pipeline registers

Function
REQ-005 FSM states SHALL be IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-006 Acceptance SHALL occur on a rising edge where req_valid and req_ready are both 1.
- Acceptance latches req_write, req_addr and req_wdata.
- Acceptance loads the down-counter with LATENCY-1 and moves the FSM to WAIT.
REQ-007 In WAIT, the counter SHALL decrement each cycle; on the edge where the counter is 0, the FSM SHALL go to RESP.
REQ-008 rsp_valid SHALL be 1 for exactly one cycle (RESP) beginning LATENCY cycles after the acceptance edge; RESP SHALL always return to IDLE.
REQ-009 The word index SHALL be latched_addr[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo DEPTH_WORDS*4.
REQ-010 A store SHALL write memory on the WAIT->RESP edge; rsp_rdata SHALL be 0 in RESP.
REQ-011 A load SHALL capture memory on the WAIT->RESP edge, reflecting every earlier completed store including the immediately preceding one.
REQ-012 stall SHALL be 1 in WAIT, 1 in IDLE when req_valid=1, and 0 in RESP, so the pipeline advances exactly in the response cycle.
REQ-013 A request asserted during RESP SHALL NOT be accepted; it is accepted on the following IDLE cycle, giving a maximum throughput of one access per LATENCY+2 cycles.
REQ-014 Request inputs SHALL be ignored outside acceptance edges; changes during WAIT SHALL NOT affect the access in flight.
REQ-015 rsp_rdata and rsp_error SHALL hold 0 whenever rsp_valid=0.

Reset
REQ-016 On reset, the block SHALL set:
- state = IDLE
- counter = 0
- rsp_valid = 0
- rsp_rdata = 0
- rsp_error = 0
- req_ready = 1 after reset deasserts
REQ-017 Reset in WAIT or RESP SHALL discard the in-flight access; a store not yet committed SHALL NOT be written.
REQ-018 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-019 Macro DMEM_MISALIGN_TRAP_EN controls misaligned-access trapping.
- Defined: an accepted request with req_addr[1:0] != 0 completes with normal latency, with no memory write, rsp_rdata = 0 and rsp_error = 1.
- Undefined: req_addr[1:0] is ignored and rsp_error is tied to 0.

Structure
REQ-020 Package dmem_pkg SHALL hold:
- the FSM state enum
- default DEPTH_WORDS and LATENCY constants
- counter width constant (4)
REQ-021 The storage array SHALL be a sub-module `dmem_sram_array`:
- synchronous write enable
- combinational read
- no reset
- all sequencing stays in dmem_responder

Verification
REQ-022 Reset, then store addr 0x10, data 0xDEADBEEF (LATENCY=2) -> rsp_valid 2 cycles after acceptance, rsp_rdata 0; stall high for the 2 cycles before rsp_valid.
REQ-023 Load addr 0x10 after REQ-022 -> rsp_rdata 0xDEADBEEF, rsp_error 0, and req_ready low for exactly LATENCY+1 cycles.
REQ-024 DEPTH_WORDS=256: store 0x12345678 to 0x400, then load 0x000 -> 0x12345678 (wrap-around).
REQ-025 Back-to-back requests with req_valid held high -> second accepted on the cycle after RESP; responses spaced LATENCY+2 cycles apart.
REQ-026 Reset asserted mid-WAIT of a store of 0xCAFEF00D to 0x20, then load 0x20 -> previous contents returned, no rsp_valid for the aborted store.
REQ-027 With DMEM_MISALIGN_TRAP_EN defined, store to 0x22 -> rsp_error 1, and a subsequent load of 0x20 shows unchanged data; without the macro, the same store writes word 0x20.
